// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - elastic EX->MEM pipeline stage with 2-entry skid buffer and perf counters
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int FLAG_W = 2,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_ALUout,
  input  logic [FLAG_W-1:0] ex_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_ALUout,
  output logic [FLAG_W-1:0] mem_zero,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_wr,
  output logic              mem_mem_rd,
  output logic              mem_mem_wr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int PW = 2*DATA_W + FLAG_W + REG_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t        state, state_n;
  logic [PW-1:0] main_q, skid_q, ex_pay;
  logic          in_fire, out_fire;
  logic          load_main, main_from_skid, load_skid;
  logic          m_reg_wr, m_mem_rd, m_mem_wr;

  assign ex_pay    = {ex_ALUout, ex_zero, ex_store_data, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr};
  // Gating with reset keeps the producer from handshaking while the stage is held in reset.
  assign ex_ready  = reset & (state != TWO);
  assign mem_valid = (state != EMPTY);
  assign in_fire   = ex_valid & ex_ready;
  assign out_fire  = mem_valid & mem_ready;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state_n   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_n = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          state_n        = ONE;
          main_from_skid = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      if (load_main)           main_q <= ex_pay;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= ex_pay;
    end
  end

  assign {mem_ALUout, mem_zero, mem_store_data, mem_rd, m_reg_wr, m_mem_rd, m_mem_wr} = main_q;
  // A stale MAIN must never look like a live register/memory write to MEM.
  assign mem_reg_wr = m_reg_wr & mem_valid;
  assign mem_mem_rd = m_mem_rd & mem_valid;
  assign mem_mem_wr = m_mem_wr & mem_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_valid && !mem_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != CNT_MAX)                   flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
